// File: rtl/aes128_hardened_pkg.sv
// Shared types and AES helper functions for the hardened AES-128 encryptor:
// S-box lookup, GF(2^8) xtime, MixColumns on one column, round constants,
// and the control FSM state encoding.
package aes128_hardened_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PASS_A = 2'd1,
    PASS_B = 2'd2,
    CHECK  = 2'd3
  } state_t;

  // S-box with entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[8 * (255 - int'(x)) +: 8];
  endfunction

  // Multiply by {02} in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // MixColumns on one column; row 0 sits in the top byte.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Round constant for rounds 1..10; other indices are never consumed.
  function automatic logic [7:0] rcon(input logic [3:0] round);
    case (round)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes128_hardened_if.sv
// Host-side handshake bundle of the hardened AES-128 encryptor.
// master = host controller, slave = encryptor.
interface aes128_hardened_if;
  logic         start;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         inject_fault;
  logic [127:0] ciphertext;
  logic         valid;
  logic         busy;
  logic         fault_alert;
  logic         noise_activity;

  modport master (
    output start, plaintext, key, inject_fault,
    input  ciphertext, valid, busy, fault_alert, noise_activity
  );

  modport slave (
    input  start, plaintext, key, inject_fault,
    output ciphertext, valid, busy, fault_alert, noise_activity
  );
endinterface

// File: rtl/aes128_round_comb.sv
// One combinational AES-128 round plus the matching key-schedule step.
// The next round key is derived from the current one and rcon, then used
// as this round's AddRoundKey operand. last=1 skips MixColumns.
module aes128_round_comb
  import aes128_hardened_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] key_in,
  input  logic [7:0]   rcon_in,
  input  logic         last,
  output logic [127:0] state_out,
  output logic [127:0] key_out
);

  logic [7:0]   sub_b [16];
  logic [127:0] shifted;
  logic [127:0] mixed;
  logic [31:0]  w [4];
  logic [31:0]  nw [4];
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;

  // Byte gi is row (gi % 4), column (gi / 4); byte 0 is the top byte.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_sub
      assign sub_b[gi] = sbox(state_in[127 - 8*gi -: 8]);
    end
    for (genvar gi = 0; gi < 16; gi++) begin : g_shift
      // Row r rotates left by r: (r, c) takes the byte from (r, c + r).
      assign shifted[127 - 8*gi -: 8] = sub_b[(gi % 4) + 4 * (((gi / 4) + (gi % 4)) % 4)];
    end
    for (genvar gi = 0; gi < 4; gi++) begin : g_mix
      assign mixed[127 - 32*gi -: 32] = mix_column(shifted[127 - 32*gi -: 32]);
    end
    for (genvar gi = 0; gi < 4; gi++) begin : g_key
      assign w[gi] = key_in[127 - 32*gi -: 32];
      assign sub_word[31 - 8*gi -: 8] = sbox(rot_word[31 - 8*gi -: 8]);
      assign key_out[127 - 32*gi -: 32] = nw[gi];
    end
  endgenerate

  assign rot_word = {w[3][23:0], w[3][31:24]};
  assign nw[0]    = w[0] ^ sub_word ^ {rcon_in, 24'h000000};
  assign nw[1]    = w[1] ^ nw[0];
  assign nw[2]    = w[2] ^ nw[1];
  assign nw[3]    = w[3] ^ nw[2];

  assign state_out = (last ? shifted : mixed) ^ key_out;

endmodule

// File: rtl/aes128_hardened.sv
// Iterative AES-128 encryptor with temporal redundancy: each block is
// encrypted twice (PASS_A, PASS_B), the results compared in CHECK, and the
// ciphertext released only when both agree; otherwise fault_alert latches.
// Optional noise generation is built when NOISE_GEN_EN is defined.
module aes128_hardened
  import aes128_hardened_pkg::*;
#(
  parameter int FAULT_ROUND = 5
`ifdef NOISE_GEN_EN
  ,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
`endif
) (
  input  logic            clk,
  input  logic            rst,
  aes128_hardened_if.slave bus
);

  state_t       fsm_reg, fsm_next;
  logic [127:0] aes_state_reg;
  logic [127:0] rkey_reg;
  logic [127:0] pt_reg;
  logic [127:0] key_reg;
  logic         inject_reg;
  logic [3:0]   round_reg;
  logic [127:0] ct_a_reg;
  logic [127:0] ciphertext_reg;
  logic         valid_reg;
  logic         fault_reg;

  logic         busy, load, run, swap, check;
  logic         last_round;
  logic         fault_hit;
  logic [127:0] round_out;
  logic [127:0] key_next;

  assign last_round = (round_reg == 4'd10);
  assign fault_hit  = (fsm_reg == PASS_B) && inject_reg && (round_reg == 4'(FAULT_ROUND));

  aes128_round_comb u_round (
    .state_in  (aes_state_reg),
    .key_in    (rkey_reg),
    .rcon_in   (rcon(round_reg)),
    .last      (last_round),
    .state_out (round_out),
    .key_out   (key_next)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) fsm_reg <= IDLE;
    else     fsm_reg <= fsm_next;
  end

  // FSM next-state: two ten-round passes, then one compare cycle.
  always_comb begin
    fsm_next = fsm_reg;
    case (fsm_reg)
      IDLE:    if (bus.start) fsm_next = PASS_A;
      PASS_A:  if (last_round) fsm_next = PASS_B;
      PASS_B:  if (last_round) fsm_next = CHECK;
      CHECK:   fsm_next = IDLE;
      default: fsm_next = IDLE;
    endcase
  end

  // FSM outputs: busy flag and datapath strobes.
  always_comb begin
    busy  = 1'b1;
    load  = 1'b0;
    run   = 1'b0;
    swap  = 1'b0;
    check = 1'b0;
    case (fsm_reg)
      IDLE: begin
        busy = 1'b0;
        load = bus.start;
      end
      PASS_A: begin
        run  = 1'b1;
        swap = last_round;
      end
      PASS_B:  run = 1'b1;
      CHECK:   check = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Datapath: capture, round iteration, pass handover, and final compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      aes_state_reg  <= '0;
      rkey_reg       <= '0;
      pt_reg         <= '0;
      key_reg        <= '0;
      inject_reg     <= 1'b0;
      round_reg      <= 4'd0;
      ct_a_reg       <= '0;
      ciphertext_reg <= '0;
      valid_reg      <= 1'b0;
      fault_reg      <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      if (load) begin
        pt_reg         <= bus.plaintext;
        key_reg        <= bus.key;
        inject_reg     <= bus.inject_fault;
        aes_state_reg  <= bus.plaintext ^ bus.key;
        rkey_reg       <= bus.key;
        round_reg      <= 4'd1;
        ciphertext_reg <= '0;
        fault_reg      <= 1'b0;
      end else if (swap) begin
        // End of pass A: park the result and restart from the captured inputs.
        ct_a_reg      <= round_out;
        aes_state_reg <= pt_reg ^ key_reg;
        rkey_reg      <= key_reg;
        round_reg     <= 4'd1;
      end else if (run) begin
        aes_state_reg <= round_out ^ {127'd0, fault_hit};
        rkey_reg      <= key_next;
        round_reg     <= round_reg + 4'd1;
      end else if (check) begin
        if (aes_state_reg == ct_a_reg) begin
          ciphertext_reg <= ct_a_reg;
          valid_reg      <= 1'b1;
          fault_reg      <= 1'b0;
        end else begin
          ciphertext_reg <= '0;
          fault_reg      <= 1'b1;
        end
      end
    end
  end

  assign bus.ciphertext  = ciphertext_reg;
  assign bus.valid       = valid_reg;
  assign bus.busy        = busy;
  assign bus.fault_alert = fault_reg;

`ifdef NOISE_GEN_EN
  logic [15:0] lfsr_reg;
  logic [31:0] dummy_reg;
  logic        noise_reg;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

  // Noise: LFSR-masked state bytes fold into a dummy register while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_reg  <= LFSR_SEED;
      dummy_reg <= '0;
      noise_reg <= 1'b0;
    end else if (busy) begin
      lfsr_reg  <= {lfsr_reg[14:0], lfsr_fb};
      dummy_reg <= dummy_reg ^ (aes_state_reg[31:0] & {lfsr_reg, lfsr_reg});
      noise_reg <= ^dummy_reg;
    end else begin
      noise_reg <= 1'b0;
    end
  end

  assign bus.noise_activity = noise_reg & busy;
`else
  assign bus.noise_activity = 1'b0;
`endif

endmodule

// File: tb/tb_aes128_hardened.sv
// Directed-vector bench for aes128_hardened: known-answer vectors, fault
// injection, start-while-busy, mid-operation reset and back-to-back streaming.
module tb_aes128_hardened;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes128_hardened_if bus ();

  aes128_hardened dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT2  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT2  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] CT0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Runs one block from idle (#1 after an edge). restart_at >= 0 pulses a
  // stray start that many cycles into the operation; b2b skips the idle tail.
  task automatic run_op(input string name, input logic [127:0] pt, input logic [127:0] k,
                        input logic inj, input int restart_at, input logic b2b,
                        input logic [127:0] exp_ct);
    int cycles     = 0;
    int valid_seen = 0;
    int valid_at   = -1;
    int both_high  = 0;
    int busy_after = 0;
    logic [127:0] ct_seen;
    logic         alert_seen;
    bus.plaintext    = pt;
    bus.key          = k;
    bus.inject_fault = inj;
    bus.start        = 1'b1;
    @(posedge clk); #1;
    bus.start        = 1'b0;
    bus.plaintext    = ~pt;
    bus.key          = ~k;
    bus.inject_fault = ~inj;
    check_value({name, " busy_after_start"}, 128'(bus.busy), 128'd1);
    while (bus.busy && cycles < 40) begin
      bus.start = (cycles == restart_at);
      @(posedge clk); #1;
      bus.start = 1'b0;
      cycles++;
      if (bus.valid) begin
        valid_seen++;
        valid_at = cycles;
      end
      if (bus.valid && bus.fault_alert) both_high++;
    end
    ct_seen    = bus.ciphertext;
    alert_seen = bus.fault_alert;
    check_value({name, " busy_cycles"}, 128'(cycles), 128'd21);
    check_value({name, " ciphertext"}, ct_seen, inj ? 128'd0 : exp_ct);
    check_value({name, " fault_alert"}, 128'(alert_seen), 128'(inj));
    check_value({name, " valid_and_alert"}, 128'(both_high), 128'd0);
    if (!inj) check_value({name, " valid_cycle"}, 128'(valid_at), 128'd21);
    if (!b2b) begin
      repeat (3) begin
        @(posedge clk); #1;
        if (bus.valid) valid_seen++;
        if (bus.busy) busy_after++;
      end
      check_value({name, " busy_after_done"}, 128'(busy_after), 128'd0);
      check_value({name, " alert_held"}, 128'(bus.fault_alert), 128'(inj));
      check_value({name, " ct_held"}, bus.ciphertext, inj ? 128'd0 : exp_ct);
    end
    check_value({name, " valid_pulses"}, 128'(valid_seen), inj ? 128'd0 : 128'd1);
    $display("op %-12s ct=%h cycles=%0d valid_pulses=%0d alert=%b",
             name, ct_seen, cycles, valid_seen, alert_seen);
  endtask

  logic [127:0] s_pt  [3];
  logic [127:0] s_key [3];
  logic [127:0] s_ct  [3];

  initial begin
    int pulses;
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.plaintext    = '0;
    bus.key          = '0;
    bus.inject_fault = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    check_value("reset ciphertext", bus.ciphertext, 128'd0);
    check_value("reset valid", 128'(bus.valid), 128'd0);
    check_value("reset busy", 128'(bus.busy), 128'd0);
    check_value("reset fault_alert", 128'(bus.fault_alert), 128'd0);
    check_value("reset noise", 128'(bus.noise_activity), 128'd0);
    $display("op reset       outputs cleared");

    run_op("fips_c1", PT1, KEY1, 1'b0, -1, 1'b0, CT1);
    run_op("sp800_38a", PT2, KEY2, 1'b0, -1, 1'b0, CT2);
    run_op("injected", PT2, KEY2, 1'b1, -1, 1'b0, CT2);
    run_op("clear_alert", PT2, KEY2, 1'b0, -1, 1'b0, CT2);
    run_op("zero_restart", 128'd0, 128'd0, 1'b0, 5, 1'b0, CT0);

    // Reset lands on edge T+8 of an operation.
    bus.plaintext = PT2;
    bus.key       = KEY2;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_value("midrst ciphertext", bus.ciphertext, 128'd0);
    check_value("midrst valid", 128'(bus.valid), 128'd0);
    check_value("midrst busy", 128'(bus.busy), 128'd0);
    check_value("midrst fault_alert", 128'(bus.fault_alert), 128'd0);
    check_value("midrst noise", 128'(bus.noise_activity), 128'd0);
    pulses = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.valid || bus.fault_alert || bus.busy) pulses++;
    end
    check_value("midrst quiet", 128'(pulses), 128'd0);
    $display("op mid_reset   quiet_cycles_with_activity=%0d", pulses);
    run_op("after_reset", PT1, KEY1, 1'b0, -1, 1'b0, CT1);

    // Back-to-back stream: each start issued the cycle busy drops.
    s_pt[0] = PT1;    s_key[0] = KEY1;   s_ct[0] = CT1;
    s_pt[1] = 128'd0; s_key[1] = 128'd0; s_ct[1] = CT0;
    s_pt[2] = PT2;    s_key[2] = KEY2;   s_ct[2] = CT2;
    for (int i = 0; i < 3; i++) begin
      run_op($sformatf("stream%0d", i), s_pt[i], s_key[i], 1'b0, -1, 1'b1, s_ct[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
